// File: rtl/forwarding_hazard_unit.sv
// EX-stage operand forwarding selects and load-use stall control for a 5-stage MIPS pipeline.
// Keeps shadow copies of destination/write-enable state for the instructions ahead of ID.
module forwarding_hazard_unit #(
   parameter int REG_BITS = 5,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [REG_BITS-1:0] id_rs,
   input  logic [REG_BITS-1:0] id_rt,
   input  logic                id_uses_rt,
   input  logic [REG_BITS-1:0] id_dest,
   input  logic                id_regwrite,
   input  logic                id_memread,
   input  logic                flush,
   output logic [1:0]          forward_a,
   output logic [1:0]          forward_b,
   output logic                stall,
   output logic                pc_write,
   output logic                ifid_write,
   output logic                idex_bubble,
   output logic [CNT_BITS-1:0] stall_count
);

   // MEM/WB needs no shadow: that writer is resolved by register-file write-before-read,
   // and a load in EX/MEM is already forwardable, so memread is only tracked in ID/EX.
   logic [REG_BITS-1:0] e_dest;
   logic                e_regwrite;
   logic                e_memread;
   logic [REG_BITS-1:0] m_dest;
   logic                m_regwrite;

   logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt;
   logic advance;
   logic [1:0] fa_next, fb_next;

   always_comb begin
      e_hit_rs = e_regwrite && (e_dest != '0) && (e_dest == id_rs);
      e_hit_rt = e_regwrite && (e_dest != '0) && (e_dest == id_rt);
      m_hit_rs = m_regwrite && (m_dest != '0) && (m_dest == id_rs);
      m_hit_rt = m_regwrite && (m_dest != '0) && (m_dest == id_rt);

      stall = !rst && id_valid && !flush && e_memread && (e_dest != '0) &&
              ((e_dest == id_rs) || (id_uses_rt && (e_dest == id_rt)));

      pc_write    = !stall;
      ifid_write  = !stall;
      idex_bubble = !rst && (stall || flush);
      advance     = id_valid && !stall && !flush;

      fa_next = 2'b00;
      if (e_hit_rs)      fa_next = 2'b10;
      else if (m_hit_rs) fa_next = 2'b01;

      fb_next = 2'b00;
      if (id_uses_rt) begin
         if (e_hit_rt)      fb_next = 2'b10;
         else if (m_hit_rt) fb_next = 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         e_dest      <= '0;
         e_regwrite  <= 1'b0;
         e_memread   <= 1'b0;
         m_dest      <= '0;
         m_regwrite  <= 1'b0;
         forward_a   <= 2'b00;
         forward_b   <= 2'b00;
         stall_count <= '0;
      end else begin
         m_dest     <= e_dest;
         m_regwrite <= e_regwrite;
         if (advance) begin
            e_dest     <= id_dest;
            e_regwrite <= id_regwrite;
            e_memread  <= id_memread;
            forward_a  <= fa_next;
            forward_b  <= fb_next;
         end else begin
            e_dest     <= '0;
            e_regwrite <= 1'b0;
            e_memread  <= 1'b0;
            forward_a  <= 2'b00;
            forward_b  <= 2'b00;
         end
         if (stall && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
      end
   end

endmodule
